// File: rtl/rd_wb_unit_pkg.sv
// Shared types and constants for the register-file write-back unit.
// The load_align funct3 codes are shared with the store path checker.
package rd_wb_unit_pkg;

  localparam int REG_LEN = 32;

  typedef enum logic [1:0] {
    RD_IMM  = 2'b00,
    RD_PCP4 = 2'b01,
    RD_ALU  = 2'b10,
    RD_MEM  = 2'b11
  } rd_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_MEM
  } wb_state_e;

endpackage

// File: rtl/rd_wb_unit_if.sv
// Request/result bundle between decode/ALU/data-memory and the write-back unit.
// The slave side is the write-back unit; the master side is the pipeline around it.
interface rd_wb_if
  import rd_wb_unit_pkg::*;
#(
  parameter int XLEN    = REG_LEN,
  parameter int RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  rd_sel_e            rd_sel;
  logic [RADDR_W-1:0] rd_addr;
  logic               rd_we;
  logic [XLEN-1:0]    imm;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    alu_out;
  logic [XLEN-1:0]    mem_rdata;
  logic [2:0]         mem_funct3;
  logic [1:0]         mem_addr_lo;
  logic               mem_valid;
  logic [XLEN-1:0]    rd_d;
  logic [RADDR_W-1:0] rd_addr_o;
  logic               rd_we_o;
  logic               wb_valid;
  logic               load_err;

  modport slave (
    input  in_valid, rd_sel, rd_addr, rd_we, imm, pc, alu_out,
           mem_rdata, mem_funct3, mem_addr_lo, mem_valid,
    output in_ready, rd_d, rd_addr_o, rd_we_o, wb_valid, load_err
  );

  modport master (
    output in_valid, rd_sel, rd_addr, rd_we, imm, pc, alu_out,
           mem_rdata, mem_funct3, mem_addr_lo, mem_valid,
    input  in_ready, rd_d, rd_addr_o, rd_we_o, wb_valid, load_err
  );
endinterface

// File: rtl/rd_wb_unit_load_align.sv
// Combinational load aligner: picks the addressed byte/half/word and extends it.
// Misaligned or unknown load types flag o_err and force o_data to zero.
module rd_wb_unit_load_align
  import rd_wb_unit_pkg::*;
#(
  parameter int XLEN = REG_LEN
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  output logic [XLEN-1:0] o_data,
  output logic            o_err
);

  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_data;
  logic            w_err;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    w_data = '0;
    w_err  = 1'b0;
    case (i_funct3)
      F3_LB:  w_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU: w_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH: begin
        w_data = {{(XLEN-16){w_half[15]}}, w_half};
        w_err  = i_addr_lo[0];
      end
      F3_LHU: begin
        w_data = {{(XLEN-16){1'b0}}, w_half};
        w_err  = i_addr_lo[0];
      end
      F3_LW: begin
        w_data = i_rdata;
        w_err  = (i_addr_lo != 2'd0);
      end
      default: w_err = 1'b1;
    endcase
  end

  assign o_err  = w_err;
  assign o_data = w_err ? '0 : w_data;

endmodule

// File: rtl/rd_wb_unit.sv
// Write-back unit: selects the rd source, delays pc for RD_PCP4, aligns loads,
// and registers one result per accepted request; stalls the front end during loads.
module rd_wb_unit
  import rd_wb_unit_pkg::*;
#(
  parameter int XLEN     = REG_LEN,
  parameter int PC_DELAY = 1,
  parameter int RADDR_W  = 5
) (
  input  logic clk,
  input  logic rst,
  rd_wb_if.slave bus
);

  wb_state_e          r_state, w_state_n;
  logic [XLEN-1:0]    r_rd_d, w_rd_d_n;
  logic [RADDR_W-1:0] r_rd_addr_o, w_rd_addr_n;
  logic               r_rd_we_o, w_rd_we_n;
  logic               r_wb_valid, w_wb_valid_n;
  logic               r_load_err, w_load_err_n;

  logic [RADDR_W-1:0] r_ld_addr, w_ld_addr_n;
  logic               r_ld_we, w_ld_we_n;
  logic [2:0]         r_ld_funct3, w_ld_funct3_n;
  logic [1:0]         r_ld_addr_lo, w_ld_addr_lo_n;

  logic [XLEN-1:0]    w_pc_sel;
  logic [XLEN-1:0]    w_src;
  logic [XLEN-1:0]    w_ld_data;
  logic               w_ld_err;
  logic               w_in_ready;
  logic               w_accept;

  // The delay line runs every cycle, independent of the handshake.
  generate
    if (PC_DELAY == 0) begin : g_pc_pass
      assign w_pc_sel = bus.pc;
    end else begin : g_pc_dly
      logic [XLEN-1:0] r_pc_dly [PC_DELAY];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PC_DELAY; i++) r_pc_dly[i] <= '0;
        end else begin
          r_pc_dly[0] <= bus.pc;
          for (int i = 1; i < PC_DELAY; i++) r_pc_dly[i] <= r_pc_dly[i-1];
        end
      end
      assign w_pc_sel = r_pc_dly[PC_DELAY-1];
    end
  endgenerate

  rd_wb_unit_load_align #(.XLEN(XLEN)) u_load_align (
    .i_rdata   (bus.mem_rdata),
    .i_funct3  (r_ld_funct3),
    .i_addr_lo (r_ld_addr_lo),
    .o_data    (w_ld_data),
    .o_err     (w_ld_err)
  );

  assign w_in_ready = (r_state == ST_IDLE);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_comb begin
    w_src = bus.alu_out;
    case (bus.rd_sel)
      RD_IMM:  w_src = bus.imm;
      RD_PCP4: w_src = w_pc_sel;
      RD_ALU:  w_src = bus.alu_out;
      default: w_src = bus.alu_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rd_d       <= '0;
      r_rd_addr_o  <= '0;
      r_rd_we_o    <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_load_err   <= 1'b0;
      r_ld_addr    <= '0;
      r_ld_we      <= 1'b0;
      r_ld_funct3  <= '0;
      r_ld_addr_lo <= '0;
    end else begin
      r_state      <= w_state_n;
      r_rd_d       <= w_rd_d_n;
      r_rd_addr_o  <= w_rd_addr_n;
      r_rd_we_o    <= w_rd_we_n;
      r_wb_valid   <= w_wb_valid_n;
      r_load_err   <= w_load_err_n;
      r_ld_addr    <= w_ld_addr_n;
      r_ld_we      <= w_ld_we_n;
      r_ld_funct3  <= w_ld_funct3_n;
      r_ld_addr_lo <= w_ld_addr_lo_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_rd_d_n       = r_rd_d;
    w_rd_addr_n    = r_rd_addr_o;
    w_rd_we_n      = 1'b0;
    w_wb_valid_n   = 1'b0;
    w_load_err_n   = 1'b0;
    w_ld_addr_n    = r_ld_addr;
    w_ld_we_n      = r_ld_we;
    w_ld_funct3_n  = r_ld_funct3;
    w_ld_addr_lo_n = r_ld_addr_lo;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (bus.rd_sel != RD_MEM) begin
            w_wb_valid_n = 1'b1;
            w_rd_d_n     = w_src;
            w_rd_addr_n  = bus.rd_addr;
            w_rd_we_n    = bus.rd_we && (bus.rd_addr != '0);
          end else begin
            w_ld_addr_n    = bus.rd_addr;
            w_ld_we_n      = bus.rd_we;
            w_ld_funct3_n  = bus.mem_funct3;
            w_ld_addr_lo_n = bus.mem_addr_lo;
            w_state_n      = ST_WAIT_MEM;
          end
        end
      end
      ST_WAIT_MEM: begin
        if (bus.mem_valid) begin
          w_wb_valid_n = 1'b1;
          w_load_err_n = w_ld_err;
          w_rd_d_n     = w_ld_data;
          w_rd_addr_n  = r_ld_addr;
          w_rd_we_n    = r_ld_we && (r_ld_addr != '0) && !w_ld_err;
          w_state_n    = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.rd_d      = r_rd_d;
  assign bus.rd_addr_o = r_rd_addr_o;
  assign bus.rd_we_o   = r_rd_we_o;
  assign bus.wb_valid  = r_wb_valid;
  assign bus.load_err  = r_load_err;

endmodule

// File: doc/rd_wb_unit.md
Name: rd_wb_unit

Overview:
- Parametrised register-file write-back unit; successor to the plain rd-select mux.
- Sits between decode/ALU/data-memory and reg_file: selects the rd source, delays PC by a configurable depth, and aligns and sign-extends load data.
- Registers the result for one cycle and stalls the front end via a ready/valid handshake while a load is outstanding.

Parameters:
- XLEN, 32, data/register width (REG_LEN in rysy_pkg.v).
- PC_DELAY, 1, number of register stages on the pc input used for RD_PCP4; 0..4, 0 = combinational pass-through.
- RADDR_W, 5, rd address width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  write-back request presented
- in_ready  out  1  unit can accept a request this cycle
- rd_sel  in  2  source select: RD_IMM 00, RD_PCP4 01, RD_ALU 10, RD_MEM 11
- rd_addr  in  RADDR_W  destination register
- rd_we  in  1  request writes the register file
- imm  in  XLEN  immediate from decode
- pc  in  XLEN  program counter
- alu_out  in  XLEN  ALU result
- mem_rdata  in  XLEN  raw word from data memory
- mem_funct3  in  3  load type, sampled with the request
- mem_addr_lo  in  2  byte offset of the load address, sampled with the request
- mem_valid  in  1  mem_rdata valid this cycle
- rd_d  out  XLEN  registered write-back data
- rd_addr_o  out  RADDR_W  registered destination
- rd_we_o  out  1  register-file write enable, one-cycle pulse
- wb_valid  out  1  result valid, one-cycle pulse
- load_err  out  1  misaligned or illegal load, one-cycle pulse with wb_valid

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, in_ready=1 the following cycle; rd_d=0, rd_addr_o=0, rd_we_o=0, wb_valid=0, load_err=0; PC delay stages=0. Reset in WAIT_MEM abandons the load and produces no write-back.
- Accept: in_valid && in_ready at a clk edge.
- in_ready=1 only in IDLE.
- PC delay line shifts every cycle regardless of the handshake. RD_PCP4 selects pc delayed by PC_DELAY cycles.
- IDLE, accepted with rd_sel != RD_MEM:
  - next cycle: wb_valid=1, rd_d=selected source, rd_addr_o=rd_addr, rd_we_o = rd_we && (rd_addr != 0).
  - Latency 1; back-to-back accepts give one result per cycle. Stay IDLE.
- IDLE, accepted with rd_sel == RD_MEM:
  - latch rd_addr, rd_we, funct3, addr_lo; go to WAIT_MEM.
  - mem_valid in the accept cycle is ignored.
- WAIT_MEM:
  - in_ready=0; in_valid ignored.
  - On the first cycle with mem_valid=1, next cycle: wb_valid=1 and aligned data on rd_d; return to IDLE.
  - No timeout; waits indefinitely.
- mem_valid in IDLE: ignored.
- Alignment: byte index=addr_lo, half index=addr_lo[1].
  - LB 000 sign-extends byte; LBU 100 zero-extends byte.
  - LH 001 sign-extends half; LHU 101 zero-extends half.
  - LW 010 passes the full word.
- Errors: LH/LHU with addr_lo[0]=1, LW with addr_lo!=0, or funct3 in {011,110,111} give load_err=1, rd_d=0, rd_we_o=0, wb_valid=1.
- rd_addr=0: wb_valid still pulses; rd_we_o=0.
- Outputs hold their last rd_d/rd_addr_o between pulses. wb_valid, rd_we_o and load_err are 0 except in result cycles.

Decomposition:
- rysy_pkg.v holds RD_IMM/RD_PCP4/RD_ALU/RD_MEM, funct3 codes F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, and REG_LEN.
- One combinational sub-module, load_align (rdata, funct3, addr_lo -> data, err), reused later by the store path checker.

Test Plan:
1. Reset with rst=1 for 2 cycles, then release -> all outputs 0, in_ready=1.
2. Back-to-back RD_ALU alu_out=0x0000_1234 rd=5, then RD_IMM imm=0xFFFF_F800 rd=6 -> two consecutive wb_valid pulses with matching rd_d/rd_addr_o, rd_we_o=1 both.
3. PC_DELAY=2: pc stepping 0x100, 0x104, 0x108…; RD_PCP4 accepted while pc=0x108 -> rd_d=0x100.
4. Loads from mem_rdata=0x80FF_7F01:
   - LB off 3 -> 0xFFFF_FF80; LBU off 3 -> 0x0000_0080.
   - LH off 2 -> 0xFFFF_80FF; LW off 0 -> 0x80FF_7F01.
   - Each with mem_valid 3 cycles after accept: in_ready low throughout, in_valid held high is not accepted.
5. LW off 1, and funct3=011 -> load_err=1, rd_d=0, rd_we_o=0, wb_valid=1.
6. RD_ALU to rd=0 -> wb_valid=1, rd_we_o=0. Then an RD_MEM accept followed by rst before mem_valid -> no wb_valid, in_ready=1 after reset.
